clock_gen_ctrl: RTL
===================

# clock_gen_ctrl

Parametrised multi-channel clock generator with run/halt/single-step control of the CPU clock. It divides the board clock into `NUM_CH` independent, runtime-programmable 50 % duty clocks. Channel 0 drives the CPU and RAM, and it can be run, halted glitch-free in its low phase, or advanced one period per debounced button press. The block sits at top level and replaces the fixed-ratio divider.

## Interface
Parameters:
- `NUM_CH`, default 4: number of output channels (≥1).
- `DIV_W`, default 32: width of each half-period divisor.
- `DEBOUNCE_CYCLES`, default 250_000: stable-level cycles required on the step button (10 ms at 25 MHz).
- `CNT_W`, default 16: width of the channel-0 rising-edge counter.

Ports:
- `clk` in 1: board clock. One clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `div` in NUM_CH*DIV_W: packed half-period lengths; channel i occupies bits [i*DIV_W +: DIV_W].
- `mode` in 2: channel-0 mode. 00 RUN, 01 HALT, 10 STEP, 11 treated as HALT.
- `step_btn` in 1: raw, asynchronous, active-high button.
- `clk_out` out NUM_CH: divided clocks, registered.
- `rise_tick` out NUM_CH: one-cycle pulse in the first cycle each `clk_out[i]` is high.
- `halted` out 1: high while channel 0 is stopped low.
- `cycle_count` out CNT_W: number of channel-0 rising edges; wraps.

## Operation
- **Channel i, free-running:**
  - Counter counts 0 up to `div[i]-1`. At terminal, `clk_out[i]` toggles and the counter clears.
  - f_out = f_clk / (2*div[i]).
  - Terminal test is `cnt >= div[i]-1`, so a divisor decrease takes effect at once and never causes a wrap-around overrun.
- **`div[i]==0`:** output is held 0, the counter is held 0, and `rise_tick[i]` stays 0.
- **Channels 1..NUM_CH-1:** always free-running.
- **Channel 0 FSM:** states HALTED, RUN, STEP.
  - HALTED: output 0, counter 0, `halted=1`.
    - If mode==RUN and `div[0]!=0`: go to RUN. Output rises the next cycle and a high phase starts.
    - If mode==STEP and a press event occurs: go to STEP. Output rises the next cycle.
  - RUN: free-running.
    - A terminal reached while the output is low and mode!=RUN suppresses the rising toggle, clears the counter and goes to HALTED.
    - The high phase is always completed, and the low phase is always at least `div[0]` cycles long. No runt pulses.
  - STEP: runs exactly one high phase of `div[0]` cycles, then a falling toggle, then goes to HALTED (low held from there).
    - Mode changes during STEP are ignored until it finishes.
    - Press events during STEP are dropped, not queued.
  - `div[0]` becoming 0 in any state forces HALTED the next cycle with output 0.
- **Step button path:**
  - 2-flop synchroniser, then a debouncer.
  - A press event is a single-cycle pulse after the synchronised level has been stable high for `DEBOUNCE_CYCLES` consecutive cycles.
  - The next press requires stable low for `DEBOUNCE_CYCLES` first.
  - Any level change restarts the stability count.
- **`cycle_count`:** increments on every `rise_tick[0]`; wraps from all-ones to 0.

## Timing
- Reset values: all `clk_out`=0, `rise_tick`=0, `cycle_count`=0, `halted`=1, FSM=HALTED, counters 0, debouncer released (stable-low satisfied).
- Reset is asynchronous. Asserting it mid-phase drives outputs to their reset values immediately.
- `rise_tick[i]` is asserted in the same cycle `clk_out[i]` is first high, and is high for exactly one cycle.
- Step latency:
  - Button edge to press pulse: 2 (sync) + `DEBOUNCE_CYCLES` cycles.
  - Press pulse to `clk_out[0]` high: 1 cycle.
  - Total step period: 2*`div[0]` cycles, including the trailing low phase before the next step can start.
- HALT latency: at most 2*`div[0]` cycles from the mode change to `halted=1`.
- `halted` is registered. It rises in the same cycle the FSM enters HALTED and falls in the cycle the output rises.

## Structure
- Package `clock_gen_pkg` holds:
  - enum `ch0_mode_t` (RUN, HALT, STEP, RSVD);
  - enum `ch0_state_t`;
  - mode encoding constants.
- Sub-module `btn_debounce`: synchroniser, stability counter (width $clog2(DEBOUNCE_CYCLES+1)) and press pulse; parameter `CYCLES`.
- Channels 1..NUM_CH-1 are generate-loop instances of identical counter logic. Channel 0 adds the FSM.

## Test plan
- **Fast channel:** reset, `div[1]`=1 → `clk_out[1]` toggles every cycle, period 2, `rise_tick[1]` every 2nd cycle.
- **Free run:** mode=RUN, `div[0]`=25 → period 50 cycles; after 10 periods `cycle_count`=10. `div[2]`=0 → `clk_out[2]` stuck 0.
- **Halt:** RUN → HALT asserted 3 cycles into a high phase → high lasts the full 25 cycles, then low persists; `halted`=1 25 cycles after the fall.
- **Step:** mode=STEP, `DEBOUNCE_CYCLES`=16, `step_btn` bounced every 5 cycles for 60 cycles then held → exactly one 25-high/25-low period, `cycle_count` +1; a second press during that step produces no extra period.
- **Divisor change:** `div[0]` changed 25 → 5 while the counter is 20 → toggle on the next cycle, then period 10.
- **Reset mid-operation:** `reset_n` low mid-high phase → `clk_out`=0, `cycle_count`=0, `halted`=1 without waiting for a clock edge.

Source files
------------

// File: rtl/clock_gen_ctrl_pkg.sv
// Purpose: shared types and constants for the multi-channel clock generator.
//   ch0_mode_t  - channel-0 mode input encoding (RSVD behaves as HALT)
//   ch0_state_t - channel-0 run/halt/step controller states
package clock_gen_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } ch0_mode_t;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } ch0_state_t;

endpackage

// File: rtl/clock_gen_ctrl_btn_debounce.sv
// Purpose: synchronise and debounce the raw step button into a single-cycle
// press pulse. A press fires once the synchronised level has been stable high
// for CYCLES cycles; a new press needs CYCLES stable-low cycles first.
// Ports:
//   clk, reset_n - clock, async active-low reset
//   btn_i        - raw asynchronous button level (active high)
//   press_o      - one-cycle press pulse (registered)
module btn_debounce #(
  parameter int unsigned CYCLES = 250_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser plus debounce state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles the input differs from the accepted level;
  // any return to the accepted level clears the count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CW'(CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_gen_ctrl.sv
// Purpose: NUM_CH runtime-programmable 50 % duty clock dividers. Channel 0
// (CPU/RAM clock) adds run / glitch-free halt / single-step control.
// Ports:
//   clk, reset_n - board clock, async active-low reset
//   div          - packed half-period divisors, channel i at [i*DIV_W +: DIV_W]
//   mode         - channel-0 mode: 00 RUN, 01 HALT, 10 STEP, 11 HALT
//   step_btn     - raw step button
//   clk_out      - divided clocks (registered)
//   rise_tick    - one-cycle pulse in the first high cycle of each clk_out
//   halted       - channel 0 stopped low
//   cycle_count  - channel-0 rising edges, wrapping
module clock_gen_ctrl
  import clock_gen_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DIV_W           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic [MODE_W-1:0]       mode,
  input  logic                    step_btn,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise_tick,
  output logic                    halted,
  output logic [CNT_W-1:0]        cycle_count
);

  logic press;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (step_btn),
    .press_o (press)
  );

  // ---------------- channel 0 with run/halt/step control ----------------
  ch0_mode_t        mode_e;
  ch0_state_t       state_q, state_d;
  logic [DIV_W-1:0] div0;
  logic [DIV_W-1:0] cnt0_q, cnt0_d;
  logic             out0_q, out0_d;
  logic             tick0_q, tick0_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cyc_q;
  logic             term0;

  assign mode_e = ch0_mode_t'(mode);
  assign div0   = div[DIV_W-1:0];
  // >= keeps a divisor decrease from overrunning the counter
  assign term0  = (cnt0_q >= (div0 - DIV_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HALTED;
      cnt0_q   <= '0;
      out0_q   <= 1'b0;
      tick0_q  <= 1'b0;
      halted_q <= 1'b1;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt0_q   <= cnt0_d;
      out0_q   <= out0_d;
      tick0_q  <= tick0_d;
      halted_q <= halted_d;
      if (tick0_d) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  // Halting only happens at a low-phase terminal, so the high phase is never
  // cut short and the preceding low phase always lasts div0 cycles.
  always_comb begin
    state_d  = state_q;
    cnt0_d   = cnt0_q;
    out0_d   = out0_q;
    tick0_d  = 1'b0;
    halted_d = halted_q;
    if (div0 == '0) begin
      state_d  = ST_HALTED;
      cnt0_d   = '0;
      out0_d   = 1'b0;
      halted_d = 1'b1;
    end else begin
      case (state_q)
        ST_HALTED: begin
          cnt0_d   = '0;
          out0_d   = 1'b0;
          halted_d = 1'b1;
          if (mode_e == MODE_RUN || (mode_e == MODE_STEP && press)) begin
            state_d  = (mode_e == MODE_RUN) ? ST_RUN : ST_STEP;
            out0_d   = 1'b1;
            tick0_d  = 1'b1;
            halted_d = 1'b0;
          end
        end
        ST_RUN, ST_STEP: begin
          if (term0) begin
            cnt0_d = '0;
            if (out0_q) begin
              out0_d = 1'b0;
            end else if (state_q == ST_STEP || mode_e != MODE_RUN) begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end else begin
              out0_d  = 1'b1;
              tick0_d = 1'b1;
            end
          end else begin
            cnt0_d = cnt0_q + DIV_W'(1);
          end
        end
        default: state_d = ST_HALTED;
      endcase
    end
  end

  assign clk_out[0]   = out0_q;
  assign rise_tick[0] = tick0_q;
  assign halted       = halted_q;
  assign cycle_count  = cyc_q;

  // ---------------- channels 1..NUM_CH-1, always free-running ----------------
  for (genvar i = 1; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_ch;
    logic [DIV_W-1:0] cnt_q;
    logic             out_q;
    logic             tick_q;

    assign div_ch = div[i*DIV_W +: DIV_W];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (div_ch == '0) begin
        cnt_q  <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (cnt_q >= (div_ch - DIV_W'(1))) begin
        cnt_q  <= '0;
        out_q  <= ~out_q;
        tick_q <= ~out_q;
      end else begin
        cnt_q  <= cnt_q + DIV_W'(1);
        tick_q <= 1'b0;
      end
    end

    assign clk_out[i]   = out_q;
    assign rise_tick[i] = tick_q;
  end

endmodule
